// File: rtl/iq_dsp_defs.sv
// Shared definitions for the IQ demodulator: width helpers and serial word-order constants.
package iq_dsp_defs;

  localparam int unsigned ARM_I = 0;
  localparam int unsigned ARM_Q = 1;

  function automatic int unsigned dwa_width(input int unsigned dwi, input int unsigned davr,
                                            input int unsigned decim_w);
    return dwi + davr + decim_w;
  endfunction

  // Width of an index over n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/iq_accum_lane.sv
// One ADC lane: cos/sin mixers (2-clk latency) feeding I/Q accumulators and the dump shadow registers.
module iq_mixer #(
  parameter int unsigned NORMALIZE = 0,
  parameter int unsigned DWI       = 16,
  parameter int unsigned DWLO      = 18,
  parameter int unsigned DAVR      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DWI-1:0]         adc,
  input  logic signed [DWLO-1:0]        lo,
  output logic signed [DWI+DAVR-1:0]    mix
);
  localparam int unsigned DWM = DWI + DAVR;
  localparam int unsigned SH  = DWLO - 1 - DAVR;
  localparam int unsigned OW  = DWI + 6;

  logic signed [DWI:0]      x;
  logic signed [DWI+DWLO:0] prod_q;

  generate
    if (NORMALIZE != 0) begin : g_norm
      // Leaky integrator (k = 1/64) tracks the lane DC offset.
      logic signed [OW-1:0]  off_acc;
      logic signed [DWI-1:0] off;
      assign off = off_acc[OW-1:6];
      always_ff @(posedge clk) begin
        if (!rst_n) off_acc <= '0;
        else        off_acc <= off_acc + OW'(adc) - OW'(off);
      end
      assign x = {adc[DWI-1], adc} - {off[DWI-1], off};
    end else begin : g_raw
      assign x = {adc[DWI-1], adc};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
      mix    <= '0;
    end else begin
      prod_q <= x * lo;
      mix    <= DWM'(prod_q >>> SH);
    end
  end
endmodule

module iq_accum_lane
  import iq_dsp_defs::*;
#(
  parameter int unsigned NORMALIZE = 0,
  parameter int unsigned DWI       = 16,
  parameter int unsigned DWLO      = 18,
  parameter int unsigned DAVR      = 4,
  parameter int unsigned DWA       = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [DWI-1:0]  adc,
  input  logic signed [DWLO-1:0] cos,
  input  logic signed [DWLO-1:0] sin,
  input  logic                   gate_d,
  input  logic                   dump,
  input  logic                   load,
  output logic signed [DWA-1:0]  shadow_i,
  output logic signed [DWA-1:0]  shadow_q
);
  localparam int unsigned DWM = DWI + DAVR;

  logic signed [DWM-1:0] mix [2];
  logic signed [DWA-1:0] acc [2];
  logic signed [DWA-1:0] sh  [2];

  iq_mixer #(.NORMALIZE(NORMALIZE), .DWI(DWI), .DWLO(DWLO), .DAVR(DAVR)) u_mix_i (
    .clk(clk), .rst_n(rst_n), .adc(adc), .lo(cos), .mix(mix[ARM_I])
  );
  iq_mixer #(.NORMALIZE(NORMALIZE), .DWI(DWI), .DWLO(DWLO), .DAVR(DAVR)) u_mix_q (
    .clk(clk), .rst_n(rst_n), .adc(adc), .lo(sin), .mix(mix[ARM_Q])
  );

  // A dump always restarts the accumulator; the shadow only takes the frame when the serialiser can.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < 2; a++) begin
        acc[a] <= '0;
        sh[a]  <= '0;
      end
    end else if (gate_d) begin
      for (int unsigned a = 0; a < 2; a++) begin
        if (dump) begin
          acc[a] <= '0;
          if (load) sh[a] <= acc[a] + DWA'(mix[a]);
        end else begin
          acc[a] <= acc[a] + DWA'(mix[a]);
        end
      end
    end
  end

  assign shadow_i = sh[ARM_I];
  assign shadow_q = sh[ARM_Q];
endmodule

// File: rtl/iq_demod_decim.sv
// Multichannel IQ demodulator with programmable decimation and a time-multiplexed I/Q word output.
module iq_demod_decim
  import iq_dsp_defs::*;
#(
  parameter int unsigned NORMALIZE = 0,
  parameter int unsigned NCHAN     = 2,
  parameter int unsigned DWI       = 16,
  parameter int unsigned DWLO      = 18,
  parameter int unsigned DAVR      = 4,
  parameter int unsigned DECIM_W   = 8,
  localparam int unsigned DWA      = dwa_width(DWI, DAVR, DECIM_W),
  localparam int unsigned CW       = clog2_min1(NCHAN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCHAN*DWI-1:0]     adc,
  input  logic signed [DWLO-1:0]   cos,
  input  logic signed [DWLO-1:0]   sin,
  input  logic                     iq_gate,
  input  logic [DECIM_W-1:0]       decim,
  output logic signed [DWA-1:0]    out_data,
  output logic                     out_valid,
  output logic [CW-1:0]            out_chan,
  output logic                     out_iq,
  output logic                     out_sof,
  output logic                     overrun,
  input  logic                     ovr_clr
);
  localparam int unsigned NW = 2 * NCHAN;
  localparam int unsigned WW = clog2_min1(NW);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [WW-1:0]        widx;
  logic [CW-1:0]        wch;
  logic [1:0]           gate_sr;
  logic                 gate_d;
  logic [DECIM_W-1:0]   cnt, n_cur, n_eff, decim_eff;
  logic                 dump, last_word, load;
  logic signed [DWA-1:0] sh_i [NCHAN];
  logic signed [DWA-1:0] sh_q [NCHAN];

  assign gate_d    = gate_sr[1];
  assign decim_eff = (decim == '0) ? DECIM_W'(1) : decim;
  // The first gated sample of a frame uses the live decim; later samples use the latched value.
  assign n_eff     = (cnt == '0) ? decim_eff : n_cur;
  assign dump      = gate_d && (cnt == n_eff - DECIM_W'(1));
  assign last_word = (state == SEND) && (widx == WW'(NW - 1));
  assign load      = dump && ((state == IDLE) || last_word);
  assign wch       = CW'(widx >> 1);

  generate
    for (genvar g = 0; g < NCHAN; g++) begin : g_lane
      iq_accum_lane #(
        .NORMALIZE(NORMALIZE), .DWI(DWI), .DWLO(DWLO), .DAVR(DAVR), .DWA(DWA)
      ) u_lane (
        .clk(clk), .rst_n(rst_n), .adc(adc[g*DWI +: DWI]), .cos(cos), .sin(sin),
        .gate_d(gate_d), .dump(dump), .load(load),
        .shadow_i(sh_i[g]), .shadow_q(sh_q[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_sr <= '0;
      cnt     <= '0;
      n_cur   <= '0;
    end else begin
      gate_sr <= {gate_sr[0], iq_gate};
      if (gate_d) begin
        if (cnt == '0) n_cur <= decim_eff;
        cnt <= dump ? '0 : cnt + DECIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      widx      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_iq    <= 1'b0;
      out_sof   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        state <= SEND;
        widx  <= '0;
      end else if (state == SEND) begin
        if (last_word) state <= IDLE;
        else           widx  <= widx + WW'(1);
      end

      if (state == SEND) begin
        out_valid <= 1'b1;
        out_sof   <= (widx == '0);
        out_chan  <= wch;
        out_iq    <= widx[0];
        out_data  <= widx[0] ? sh_q[wch] : sh_i[wch];
      end else begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
      end

      if (dump && !load) overrun <= 1'b1;
      else if (ovr_clr)  overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iq_demod_decim.sv
// Randomised directed bench for iq_demod_decim against a cycle-indexed frame model.
module tb_iq_demod_decim;
  localparam int NCHAN = 2, DWI = 16, DWLO = 18, DAVR = 4, DECIM_W = 8;
  localparam int DWA = 28, NW = 4, CMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, iq_gate, ovr_clr;
  logic [NCHAN*DWI-1:0]   adc;
  logic signed [DWLO-1:0] cos_lo, sin_lo;
  logic [DECIM_W-1:0]     decim;
  logic signed [DWA-1:0]  out_data;
  logic                   out_valid, out_iq, out_sof, overrun;
  logic [0:0]             out_chan;

  iq_demod_decim #(
    .NORMALIZE(0), .NCHAN(NCHAN), .DWI(DWI), .DWLO(DWLO), .DAVR(DAVR), .DECIM_W(DECIM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc(adc), .cos(cos_lo), .sin(sin_lo), .iq_gate(iq_gate),
    .decim(decim), .out_data(out_data), .out_valid(out_valid), .out_chan(out_chan),
    .out_iq(out_iq), .out_sof(out_sof), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  int vectors = 0, miscompares = 0, cyc = 0, phase = 0;

  bit rst_h [CMAX], gate_h [CMAX], clr_h [CMAX];
  int adc_h [CMAX][2];
  int cos_h [CMAX], sin_h [CMAX], dec_h [CMAX];

  bit         ev [CMAX+8], esof [CMAX+8], eovr [CMAX+8], ezero [CMAX+8], eiq [CMAX+8];
  logic [0:0] echan [CMAX+8];
  logic [DWA-1:0] edata [CMAX+8];

  longint acc [2][2];
  int     cnt = 0, nfr = 1, last_acc = -1000;
  bit     ovr = 0;

  bit d_rst, d_gate, d_clr;
  int d_dec, d_cos, d_sin;
  int d_adc [2];

  logic [DWA-1:0] t1 [4];

  function automatic longint mixf(input int a, input int lo);
    longint p;
    logic signed [19:0] t;
    p = longint'(a) * longint'(lo);
    p = p >>> 13;
    t = p[19:0];
    return longint'(t);
  endfunction

  function automatic int rnd_adc();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_lo();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic model(input int c);
    bit     drop;
    int     i;
    longint t;
    drop = 0;
    if (!rst_h[c]) begin
      for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++) acc[a][b] = 0;
      cnt = 0; ovr = 0; last_acc = -1000;
      for (int k = c + 1; k < c + 8; k++) begin ev[k] = 0; esof[k] = 0; end
      eovr[c+1] = 0; ezero[c+1] = 1;
      return;
    end
    if (c >= 2 && rst_h[c-2] && rst_h[c-1] && gate_h[c-2]) begin
      i = c - 2;
      if (cnt == 0) nfr = (dec_h[c] == 0) ? 1 : dec_h[c];
      for (int ch = 0; ch < 2; ch++) begin
        acc[ch][0] += mixf(adc_h[i][ch], cos_h[i]);
        acc[ch][1] += mixf(adc_h[i][ch], sin_h[i]);
      end
      cnt++;
      if (cnt == nfr) begin
        if (c - last_acc >= NW) begin
          last_acc = c;
          for (int j = 0; j < NW; j++) begin
            ev[c+2+j]    = 1;
            esof[c+2+j]  = (j == 0);
            echan[c+2+j] = 1'(j / 2);
            eiq[c+2+j]   = 1'(j % 2);
            t = acc[j/2][j%2];
            edata[c+2+j] = t[DWA-1:0];
          end
        end else begin
          drop = 1;
        end
        for (int a = 0; a < 2; a++) for (int b = 0; b < 2; b++) acc[a][b] = 0;
        cnt = 0;
      end
    end
    if (drop) ovr = 1;
    else if (clr_h[c]) ovr = 0;
    eovr[c+1] = ovr;
  endtask

  task automatic check(input int c);
    vectors++;
    assert (out_valid === ev[c]) else begin
      miscompares++; $error("FAIL valid cyc=%0d got=%b exp=%b", c, out_valid, ev[c]);
    end
    vectors++;
    assert (out_sof === esof[c]) else begin
      miscompares++; $error("FAIL sof cyc=%0d got=%b exp=%b", c, out_sof, esof[c]);
    end
    vectors++;
    assert (overrun === eovr[c]) else begin
      miscompares++; $error("FAIL overrun cyc=%0d got=%b exp=%b", c, overrun, eovr[c]);
    end
    if (ev[c]) begin
      vectors++;
      assert (out_data === edata[c]) else begin
        miscompares++; $error("FAIL data cyc=%0d got=%0d exp=%0d", c, out_data, $signed(edata[c]));
      end
      vectors++;
      assert ({out_chan, out_iq} === {echan[c], eiq[c]}) else begin
        miscompares++; $error("FAIL chan_iq cyc=%0d got=%b%b exp=%b%b", c, out_chan, out_iq, echan[c], eiq[c]);
      end
      if (phase == 1) begin
        vectors++;
        assert (out_data === t1[{echan[c], eiq[c]}]) else begin
          miscompares++; $error("FAIL t1_const cyc=%0d got=%0d exp=%0d", c, out_data,
                                $signed(t1[{echan[c], eiq[c]}]));
        end
      end
    end
    if (ezero[c]) begin
      vectors++;
      assert ({out_data, out_chan, out_iq} === '0) else begin
        miscompares++; $error("FAIL reset_zero cyc=%0d got=%0d/%b/%b exp=0/0/0", c, out_data, out_chan, out_iq);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc > 0) check(cyc);
    rst_n   = d_rst;
    iq_gate = d_gate;
    ovr_clr = d_clr;
    decim   = d_dec[DECIM_W-1:0];
    adc     = {d_adc[1][15:0], d_adc[0][15:0]};
    cos_lo  = d_cos[17:0];
    sin_lo  = d_sin[17:0];
    rst_h[cyc] = d_rst; gate_h[cyc] = d_gate; clr_h[cyc] = d_clr;
    dec_h[cyc] = d_dec; cos_h[cyc] = d_cos; sin_h[cyc] = d_sin;
    adc_h[cyc][0] = d_adc[0]; adc_h[cyc][1] = d_adc[1];
    model(cyc);
    cyc++;
  endtask

  task automatic rnd_data();
    d_adc[0] = rnd_adc(); d_adc[1] = rnd_adc();
    d_cos = rnd_lo(); d_sin = rnd_lo();
  endtask

  initial begin
    bit found;
    t1[0] = 28'd63996; t1[1] = '0; t1[2] = -28'sd64000; t1[3] = '0;

    // Reset with the first scenario's stimulus already applied.
    d_rst = 0; d_gate = 1; d_clr = 0; d_dec = 4;
    d_adc[0] = 1000; d_adc[1] = -1000; d_cos = 131071; d_sin = 0;
    repeat (3) tick();
    d_rst = 1;
    phase = 1;
    repeat (40) tick();
    phase = 0;

    // decim = 1: the serialiser can only take every fourth dump.
    d_dec = 1;
    for (int k = 0; k < 20; k++) begin rnd_data(); tick(); end
    d_gate = 0;
    repeat (6) tick();
    d_clr = 1; tick();
    d_clr = 0; repeat (3) tick();

    // decim = 8 with alternating gate.
    d_dec = 8;
    for (int k = 0; k < 64; k++) begin d_gate = k[0] ? 1'b0 : 1'b1; rnd_data(); tick(); end
    d_gate = 0; repeat (6) tick();

    // decim changed mid-frame from 4 to 6.
    d_dec = 4; d_gate = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      rnd_data(); tick();
      if (cnt == 2) found = 1;
    end
    vectors++;
    assert (found) else begin miscompares++; $error("FAIL midframe_wait got=timeout exp=cnt2"); end
    d_dec = 6;
    for (int k = 0; k < 40; k++) begin rnd_data(); tick(); end

    // Reset while word 2 (ch1 I) is on the output.
    d_dec = 4;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      rnd_data();
      if (ev[cyc] && echan[cyc] == 1'b1 && !eiq[cyc]) begin
        d_rst = 0; found = 1;
      end
      tick();
    end
    vectors++;
    assert (found) else begin miscompares++; $error("FAIL word2_wait got=timeout exp=word2"); end
    d_rst = 1;
    for (int k = 0; k < 30; k++) begin rnd_data(); tick(); end

    // decim = 0 behaves as 1, then full-scale products over a 255-sample frame.
    d_dec = 0;
    for (int k = 0; k < 20; k++) begin rnd_data(); tick(); end
    d_dec = 255;
    d_adc[0] = -32768; d_adc[1] = -32768; d_cos = -131072; d_sin = 131071;
    repeat (530) tick();

    // Fully random traffic.
    for (int k = 0; k < 800; k++) begin
      rnd_data();
      d_gate = ($urandom_range(0, 9) < 7);
      d_clr  = ($urandom_range(0, 9) == 0);
      d_rst  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) d_dec = int'($urandom_range(0, 6));
      tick();
    end
    d_rst = 1; d_gate = 0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
